// File: rtl/spi_frame_master_nch.sv
// ---------------------------------------------------------------------------
// spi_frame_master_nch
//
// Multi-lane SPI frame transmitter. Each rising edge of the asynchronous
// simulation clock SIMCK launches one frame carrying NCH words of WIDTH bits,
// one word per data lane, all lanes sharing a single SCK / SSEL pair.
//
// Optional feature macro: SPI_FRAME_PARITY_EN
//   defined   -> every lane appends an even-parity bit as an extra bit cell
//   undefined -> WIDTH bit cells per frame, no parity logic
//
// Ports:
//   clk          system clock, everything on the rising edge
//   reset        synchronous, active-low reset
//   en           1 = frame triggers are accepted
//   clkdiv       SCK half-period minus one, in clk cycles
//   SIMCK        asynchronous frame trigger (rising edge)
//   data_in      lane k word = data_in[k*WIDTH +: WIDTH]
//   SCK          serial clock, idle low
//   SSEL         frame select, active low, idle high
//   DATA_OUT     per-lane serial data, MSB first
//   busy         high from LOAD through GAP
//   frame_done   one-cycle pulse on the cycle SSEL returns high
//   overrun_cnt  saturating count of triggers dropped while not idle
// ---------------------------------------------------------------------------
module spi_frame_master_nch #(
    parameter int NCH   = 2,
    parameter int WIDTH = 32,
    parameter int DIV_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [DIV_W-1:0]       clkdiv,
    input  logic                   SIMCK,
    input  logic [NCH*WIDTH-1:0]   data_in,
    output logic                   SCK,
    output logic                   SSEL,
    output logic [NCH-1:0]         DATA_OUT,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            overrun_cnt
);

`ifdef SPI_FRAME_PARITY_EN
    localparam int B = WIDTH + 1;
`else
    localparam int B = WIDTH;
`endif
    localparam int HW  = DIV_W + 1;    // holds clkdiv+1 without overflow
    localparam int CW  = DIV_W + 2;    // holds 2H-1 for the gap phase
    localparam int BCW = $clog2(B);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic                    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [HW-1:0]           h_q, h_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BCW-1:0]          bit_q, bit_d;
    logic [NCH-1:0][B-1:0]   sh_q, sh_d;
    logic                    sck_q, sck_d;
    logic                    ssel_q, ssel_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             ovr_q, ovr_d;
    logic                    trig;

    assign trig = s2_q & ~s3_q;

    // State register and all registered outputs. The shift registers double
    // as the DATA_OUT drivers, so clearing them also idles the data lanes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            h_q     <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sck_q   <= 1'b0;
            ssel_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sck_q   <= sck_d;
            ssel_q  <= ssel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic. cnt_q counts down the cycles left in the current
    // SCK phase; bit_q counts completed bit cells within SHIFT.
    always_comb begin
        s1_d    = SIMCK;
        s2_d    = s1_q;
        s3_d    = s2_q;
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sck_d   = sck_q;
        ssel_d  = ssel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        // A trigger outside IDLE (including the last GAP cycle) is dropped.
        if (trig && (state_q != ST_IDLE) && (ovr_q != 16'hFFFF))
            ovr_d = ovr_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (trig && en) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                h_d    = {1'b0, clkdiv} + HW'(1);
                cnt_d  = {2'b00, clkdiv};
                ssel_d = 1'b0;
                for (int k = 0; k < NCH; k++) begin
`ifdef SPI_FRAME_PARITY_EN
                    sh_d[k] = {data_in[k*WIDTH +: WIDTH], ^data_in[k*WIDTH +: WIDTH]};
`else
                    sh_d[k] = data_in[k*WIDTH +: WIDTH];
`endif
                end
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                    cnt_d   = {1'b0, h_q} - CW'(1);
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (sck_q) begin
                    // Falling SCK edge: present the next bit on every lane.
                    sck_d = 1'b0;
                    cnt_d = {1'b0, h_q} - CW'(1);
                    for (int k = 0; k < NCH; k++)
                        sh_d[k] = {sh_q[k][B-2:0], 1'b0};
                end else if (bit_q == BCW'(B - 1)) begin
                    // End of the hold time of the last cell.
                    state_d = ST_GAP;
                    ssel_d  = 1'b1;
                    done_d  = 1'b1;
                    sh_d    = '0;
                    cnt_d   = {h_q, 1'b0} - CW'(1);
                end else begin
                    bit_d = bit_q + BCW'(1);
                    sck_d = 1'b1;
                    cnt_d = {1'b0, h_q} - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Each lane drives the MSB of its shift register.
    always_comb begin
        DATA_OUT = '0;
        for (int k = 0; k < NCH; k++)
            DATA_OUT[k] = sh_q[k][B-1];
    end

    assign SCK         = sck_q;
    assign SSEL        = ssel_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: doc/spi_frame_master_nch.md
# spi_frame_master_nch

Parametrised multi-lane SPI frame transmitter for inter-board links: carries NCH words of WIDTH bits per simulation tick (e.g. muscle length and force) over NCH parallel data lanes sharing one SCK/SSEL pair. It sits between the simulation datapath and the board pins, launching one frame on every rising edge of the simulation clock. Compared with the fixed two-lane, 32-bit sender it replaces, it adds:
- configurable lane count and word width;
- overrun detection;
- a frame-done strobe;
- optional per-lane parity.

## Interface
Parameters:
- NCH, 2, number of data lanes (1–8)
- WIDTH, 32, bits per lane per frame (8–32)
- DIV_W, 24, width of clkdiv

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock (clk1 domain); all logic on rising edge
- reset  in  1  synchronous, active-low; 0 = reset
- en  in  1  1 = accept frame triggers
- clkdiv  in  DIV_W  SCK half-period minus one, in clk cycles
- SIMCK  in  1  frame trigger, asynchronous to clk; rising edge starts a frame
- data_in  in  NCH*WIDTH  lane k word = data_in[k*WIDTH +: WIDTH]
- SCK  out  1  serial clock, idle low
- SSEL  out  1  frame select, active low, idle high
- DATA_OUT  out  NCH  lane serial data, MSB first
- busy  out  1  frame in progress (LOAD through GAP)
- frame_done  out  1  one-cycle pulse when SSEL returns high
- overrun_cnt  out  16  saturating count of dropped triggers

## Operation
Reset (reset=0 at a clk edge) forces the following, from any state including mid-frame:
- SSEL=1, SCK=0, DATA_OUT=0, busy=0, frame_done=0, overrun_cnt=0;
- state=IDLE; synchroniser flops are cleared.

Trigger:
- SIMCK passes through a 3-flop chain s1→s2→s3; trig = s2 & ~s3.

FSM states: IDLE, LOAD, SETUP, SHIFT, GAP.
- IDLE:
  - trig & en → LOAD.
  - trig & ~en → ignored, not counted.
- LOAD (1 cycle):
  - latch data_in into NCH shift registers;
  - latch H = clkdiv+1; clkdiv changes mid-frame are ignored;
  - SSEL←0, busy←1, DATA_OUT←MSB of each lane; → SETUP.
- SETUP: SCK low for H cycles → SHIFT.
- SHIFT: B bit cells, each SCK high for H cycles then low for H cycles.
  - On each high→low transition, every lane shifts left by one.
  - The slave samples on the SCK rising edge.
  - The low phase of the last cell is the hold time.
  - After the last cell: SSEL←1, frame_done pulses, DATA_OUT←0 → GAP.
- GAP: SSEL high for 2H cycles → IDLE; busy falls on entry to IDLE.
- Overrun: trig in any state other than IDLE → trigger dropped, overrun_cnt+1 (saturates at 16'hFFFF). Applies even if en=0.
- Simultaneous events: trig in the same cycle the FSM enters IDLE counts as overrun. trig in a cycle where the FSM is already in IDLE is accepted.
- en falling mid-frame: the current frame completes.

## Timing
Bit count per frame: B = WIDTH, or WIDTH+1 with parity.

Latency from SIMCK rising edge to SSEL low: 3–4 clk cycles (synchroniser) plus 1 cycle (LOAD).

Frame durations:
- SSEL low: H + 2·H·B cycles.
- busy high: 1 + H + 2·H·B + 2H cycles.
- Defaults (clkdiv=13, H=14, B=32): SSEL low 910 cycles; busy 939 cycles.

Constraints:
- Minimum SIMCK period without overrun: busy time + 4 cycles.
- clkdiv=0 is legal: SCK = clk/2.

## Configuration
- SPI_FRAME_PARITY_EN defined:
  - each lane appends one even-parity bit (XOR of its WIDTH latched bits) as bit cell WIDTH+1;
  - B = WIDTH+1.
- SPI_FRAME_PARITY_EN undefined: B = WIDTH, and no parity logic is present.

## Test plan
- Default parameters, clkdiv=13, data_in={32'h3F80_0000, 32'hC2A0_0000}, one SIMCK edge:
  - SSEL low for exactly 910 cycles;
  - 32 SCK pulses;
  - bench slave recovers both words;
  - frame_done pulses once;
  - overrun_cnt=0.
- NCH=4, WIDTH=16, clkdiv=0, lanes 16'hA5A5 / 16'h0001 / 16'hFFFF / 16'h8000:
  - 16 SCK pulses, each 2 cycles wide (SCK = clk/2);
  - all four lanes decode correctly.
- Second SIMCK edge 100 cycles after the first:
  - first frame completes unchanged;
  - overrun_cnt=1;
  - no second frame starts.
- reset=0 held for one cycle at cycle 400 of a frame:
  - next cycle SSEL=1, SCK=0, busy=0, overrun_cnt=0;
  - next SIMCK edge produces a clean full frame.
- en=0 with a SIMCK edge: no frame and overrun_cnt stays 0. en dropped mid-frame: the frame completes.
- Parity build, WIDTH=32, word 32'h0000_0007: 33 SCK pulses; bit 33 = 1.
